// File: rtl/main.sv
// Registered modular adder/subtractor on 4-bit residues: Z <= (X +/- Y) mod m,
// with one shared raw adder, one correction adder and a 2:1 select.
module main #(
  parameter logic [3:0] m = 4'b1111
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  output logic z3,
  output logic z2,
  output logic z1,
  output logic z0
);

  localparam logic [4:0] M5 = {1'b0, m};

  logic [3:0] x_v;
  logic [3:0] y_v;
  logic [3:0] y_op;
  logic [4:0] raw;
  logic [4:0] val;
  logic [4:0] corr;
  logic       use_corr;
  logic [3:0] z_d;
  logic [3:0] z_q;

  assign x_v = {x3, x2, x1, x0};
  assign y_v = {y3, y2, y1, y0};

  always_comb begin
    y_op     = '0;
    raw      = '0;
    val      = '0;
    corr     = '0;
    use_corr = 1'b0;
    z_d      = '0;

    // Subtract reuses the adder as X + ~Y + 1; carry-out set means no borrow.
    y_op = s ? ~y_v : y_v;
    raw  = {1'b0, x_v} + {1'b0, y_op} + {4'b0000, s};

    if (s) begin
      val      = {~raw[4], raw[3:0]};
      corr     = val + M5;
      use_corr = val[4];
    end else begin
      val      = raw;
      corr     = val - M5;
      use_corr = (val >= M5);
    end

    z_d = use_corr ? corr[3:0] : val[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign {z3, z2, z1, z0} = z_q;

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for main: three instances (M = 15, 12, 9) driven per lane;
// stimulus pushes expected Z per edge, a monitor pops and compares after each edge.
module tb_main;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][3:0] xv;
  logic [2:0][3:0] yv;
  logic [2:0]      sv;
  logic [3:0]      z15, z12, z9;

  int mods[3] = '{15, 12, 9};

  main #(.m(4'd15)) u_m15 (
    .clk(clk), .rst_n(rst_n), .s(sv[0]),
    .x3(xv[0][3]), .x2(xv[0][2]), .x1(xv[0][1]), .x0(xv[0][0]),
    .y3(yv[0][3]), .y2(yv[0][2]), .y1(yv[0][1]), .y0(yv[0][0]),
    .z3(z15[3]), .z2(z15[2]), .z1(z15[1]), .z0(z15[0])
  );

  main #(.m(4'd12)) u_m12 (
    .clk(clk), .rst_n(rst_n), .s(sv[1]),
    .x3(xv[1][3]), .x2(xv[1][2]), .x1(xv[1][1]), .x0(xv[1][0]),
    .y3(yv[1][3]), .y2(yv[1][2]), .y1(yv[1][1]), .y0(yv[1][0]),
    .z3(z12[3]), .z2(z12[2]), .z1(z12[1]), .z0(z12[0])
  );

  main #(.m(4'd9)) u_m9 (
    .clk(clk), .rst_n(rst_n), .s(sv[2]),
    .x3(xv[2][3]), .x2(xv[2][2]), .x1(xv[2][1]), .x0(xv[2][0]),
    .y3(yv[2][3]), .y2(yv[2][2]), .y1(yv[2][1]), .y0(yv[2][0]),
    .z3(z9[3]), .z2(z9[2]), .z1(z9[1]), .z0(z9[0])
  );

  typedef struct packed {
    logic [2:0]      chk;
    logic [2:0][3:0] e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exh_cnt[3] = '{0, 0, 0};
  bit   exh_phase = 1'b0;

  // Reference: modular add/sub with the wrap rules applied once, result kept to 4 bits.
  function automatic int ref_z(input int x, input int y, input bit sub, input int mm);
    int t;
    if (!sub) begin
      t = x + y;
      if (t >= mm) t = t - mm;
    end else begin
      t = x - y;
      if (t < 0) t = t + mm;
    end
    return t & 15;
  endfunction

  function automatic logic [3:0] zget(input int i);
    case (i)
      0:       return z15;
      1:       return z12;
      default: return z9;
    endcase
  endfunction

  task automatic check_now(input string name, input int lane, input int exp);
    checks++;
    if (zget(lane) !== 4'(exp)) begin
      errors++;
      $display("FAIL %s: z=%0d expected %0d", name, zget(lane), exp);
    end
  endtask

  task automatic push_model(input logic [2:0] chk);
    exp_t t;
    t.chk = chk;
    for (int i = 0; i < 3; i++)
      t.e[i] = rst_n ? 4'(ref_z(int'(xv[i]), int'(yv[i]), sv[i], mods[i])) : 4'd0;
    q.push_back(t);
    @(negedge clk);
  endtask

  task automatic directed(input int lane, input int x, input int y, input bit sub, input int exp);
    exp_t t;
    xv[lane] = 4'(x);
    yv[lane] = 4'(y);
    sv[lane] = sub;
    t.chk = 3'(1 << lane);
    t.e = '0;
    t.e[lane] = 4'(exp);
    q.push_back(t);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        t = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          if (t.chk[i]) begin
            checks++;
            if (zget(i) !== t.e[i]) begin
              errors++;
              $display("FAIL z_M%0d @%0t: got %0d expected %0d", mods[i], $time, zget(i), t.e[i]);
            end else if (exh_phase) begin
              exh_cnt[i]++;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    xv = '0;
    yv = '0;
    sv = '0;
    #2;
    for (int i = 0; i < 3; i++) check_now("reset_z", i, 0);
    @(negedge clk);
    @(negedge clk);
    check_now("reset_held_after_edges", 0, 0);
    rst_n = 1'b1;

    // Directed vectors, M=15
    directed(0, 7, 9, 1'b0, 1);
    directed(0, 14, 14, 1'b0, 13);
    directed(0, 7, 8, 1'b0, 0);
    directed(0, 3, 5, 1'b1, 13);
    directed(0, 9, 9, 1'b1, 0);
    directed(0, 14, 0, 1'b1, 14);
    // M=9
    directed(2, 8, 8, 1'b0, 7);
    directed(2, 0, 8, 1'b1, 1);
    // M=12 wrap boundaries
    directed(1, 11, 1, 1'b0, 0);
    directed(1, 0, 1, 1'b1, 11);

    // Exhaustive legal operands per modulus, all lanes run side by side
    exh_phase = 1'b1;
    for (int v = 0; v < 2 * 15 * 15; v++) begin
      logic [2:0] chk;
      chk = '0;
      for (int i = 0; i < 3; i++) begin
        int mm;
        int r;
        mm = mods[i];
        if (v < 2 * mm * mm) begin
          r = v % (mm * mm);
          sv[i] = (v >= mm * mm);
          xv[i] = 4'(r / mm);
          yv[i] = 4'(r % mm);
          chk[i] = 1'b1;
        end
      end
      push_model(chk);
    end
    exh_phase = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exh_cnt[i] != 2 * mods[i] * mods[i]) begin
        errors++;
        $display("FAIL exhaustive_count_M%0d: passes=%0d expected %0d",
                 mods[i], exh_cnt[i], 2 * mods[i] * mods[i]);
      end
    end

    // Asynchronous reset between edges
    directed(0, 3, 5, 1'b1, 13);
    check_now("pre_reset_z13", 0, 13);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_clear", 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        xv[i] = 4'($urandom_range(0, 15));
        yv[i] = 4'($urandom_range(0, 15));
        sv[i] = 1'($urandom_range(0, 1));
      end
      push_model(3'b111);
    end
    rst_n = 1'b1;
    directed(0, 5, 6, 1'b0, 11);

    // Mode toggle, M=15
    for (int k = 0; k < 8; k++)
      directed(0, 10, 12, 1'(k % 2), (k % 2) ? 13 : 7);

    // Random operands including out-of-range, with occasional mid-stream reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        xv[i] = 4'($urandom_range(0, 15));
        yv[i] = 4'($urandom_range(0, 15));
        sv[i] = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 39) != 0);
      push_model(3'b111);
    end
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
